// File: rtl/mips_mem_loader.sv
// Program RAM and byte loader in front of the 8-bit multicycle mips core.
// LOAD captures pin strobes into consecutive addresses with the core held in reset; RUN serves the core.
module mips_mem_loader #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              load_strobe,
  input  logic [DWIDTH-1:0] load_data,
  input  logic [DWIDTH-1:0] cpu_adr,
  input  logic [DWIDTH-1:0] cpu_writedata,
  input  logic              cpu_memwrite,
  output logic [DWIDTH-1:0] cpu_memdata,
  output logic              cpu_reset,
  output logic [AWIDTH:0]   load_count,
  output logic              load_full,
  output logic              running
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                mode_s1_q, mode_s2_q;
  logic                strobe_s1_q, strobe_s2_q, strobe_hist_q;
  logic [AWIDTH:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                running_q, running_d;
  logic                strobe_rise_s;
  logic                adr_in_range_s;
  logic                mem_we_s;
  logic [AWIDTH-1:0]   mem_waddr_s;
  logic [DWIDTH-1:0]   mem_wdata_s;
  logic [DWIDTH-1:0]   mem [DEPTH];

  assign strobe_rise_s  = strobe_s2_q & ~strobe_hist_q;
  assign adr_in_range_s = ((cpu_adr >> AWIDTH) == '0);

  // Synchronizers, FSM state and registered status outputs.
  // Mode sync resets to 1 so the core stays in reset until a low mode has crossed the synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_s1_q     <= 1'b1;
      mode_s2_q     <= 1'b1;
      strobe_s1_q   <= 1'b0;
      strobe_s2_q   <= 1'b0;
      strobe_hist_q <= 1'b0;
      state_q       <= ST_LOAD;
      count_q       <= '0;
      full_q        <= 1'b0;
      cpu_reset_q   <= 1'b1;
      running_q     <= 1'b0;
    end else begin
      mode_s1_q     <= load_mode;
      mode_s2_q     <= mode_s1_q;
      strobe_s1_q   <= load_strobe;
      strobe_s2_q   <= strobe_s1_q;
      strobe_hist_q <= strobe_s2_q;
      state_q       <= state_d;
      count_q       <= count_d;
      full_q        <= full_d;
      cpu_reset_q   <= cpu_reset_d;
      running_q     <= running_d;
    end
  end

  // Next-state, load counter and RAM write-port selection.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    full_d      = full_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    case (state_q)
      ST_LOAD: begin
        if (strobe_rise_s && !full_q) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = count_q[AWIDTH-1:0];
          mem_wdata_s = load_data;
          count_d     = count_q + 1'b1;
          full_d      = (count_d == FULL_COUNT);
        end else begin
          count_d = count_q;
        end
        if (!mode_s2_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (cpu_memwrite && adr_in_range_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = cpu_adr[AWIDTH-1:0];
          mem_wdata_s = cpu_writedata;
        end else begin
          mem_we_s = 1'b0;
        end
        // Re-entering LOAD restarts the image from address 0.
        if (mode_s2_q) begin
          state_d = ST_LOAD;
          count_d = '0;
          full_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_LOAD;
        count_d = '0;
        full_d  = 1'b0;
      end
    endcase
    cpu_reset_d = (state_d == ST_LOAD);
    running_d   = (state_d == ST_RUN);
  end

  // RAM write port; intentionally unreset so the image survives rst.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Combinational core read; addresses beyond the RAM read as zero.
  always_comb begin
    if (adr_in_range_s) begin
      cpu_memdata = mem[cpu_adr[AWIDTH-1:0]];
    end else begin
      cpu_memdata = '0;
    end
  end

  assign load_count = count_q;
  assign load_full  = full_q;
  assign cpu_reset  = cpu_reset_q;
  assign running    = running_q;

endmodule
